// File: rtl/total_pkg.sv
// Shared constants for the Sentinel event reporter: cause bit positions,
// record width helper and the control FSM state type.
package total_pkg;

    localparam int CAUSE_ENTROPY = 0;
    localparam int CAUSE_THERM   = 1;
    localparam int CAUSE_HALT    = 2;
    localparam int CAUSE_OVF     = 3;
    localparam int EVT_CAUSE_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } ctrl_state_t;

    // A record is the cause nibble stacked on top of the timestamp.
    function automatic int EVT_W(input int ts_w);
        return ts_w + EVT_CAUSE_W;
    endfunction

endpackage

// File: rtl/total_sync_fifo.sv
// Single-clock register FIFO; pointers carry an extra wrap bit so full and
// empty are told apart without a separate counter.
module total_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + PTR_ONE;
            if (rd_en) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sentinel_event_reporter.sv
// Turns rising edges on the alarm levels into timestamped records buffered
// for software, with a sticky alarm flag and a saturating drop counter.
module sentinel_event_reporter
    import total_pkg::*;
#(
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      entropy_alarm,
    input  logic                      thermal_shutdown,
    input  logic                      system_halt,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [EVT_W(TS_W)-1:0]    evt_data,
    input  logic                      sw_ack,
    output logic                      alarm_sticky,
    output logic [DROP_W-1:0]         drop_count,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int RW = EVT_W(TS_W);

    logic [TS_W-1:0] ts;
    logic [2:0]      raw;
    logic [2:0]      cur;
    logic [2:0]      prev;
    logic [2:0]      rise;
    logic            event_hit;
    logic            ovf_pending;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            dropped;
    logic [RW-1:0]   record;
    ctrl_state_t     state;

    assign raw       = {system_halt, thermal_shutdown, entropy_alarm};
    assign rise      = cur & ~prev;
    assign event_hit = |rise;
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    assign push      = event_hit && (!fifo_full || pop);
    assign dropped   = event_hit && !push;

    always_comb begin
        record                      = '0;
        record[TS_W-1:0]            = ts;
        record[TS_W+CAUSE_ENTROPY]  = rise[CAUSE_ENTROPY];
        record[TS_W+CAUSE_THERM]    = rise[CAUSE_THERM];
        record[TS_W+CAUSE_HALT]     = rise[CAUSE_HALT];
        record[TS_W+CAUSE_OVF]      = ovf_pending;
    end

    // History resets to zero so a level already high at release counts as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts   <= '0;
            cur  <= '0;
            prev <= '0;
        end else begin
            ts   <= ts + TS_W'(1);
            cur  <= raw;
            prev <= cur;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_count  <= '0;
            ovf_pending <= 1'b0;
        end else begin
            if (dropped && (drop_count != '1)) drop_count <= drop_count + DROP_W'(1);
            if (dropped)   ovf_pending <= 1'b1;
            else if (push) ovf_pending <= 1'b0;
        end
    end

    // The sticky flag mirrors ARMED; an event in the ack cycle keeps it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            alarm_sticky <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (event_hit) begin
                        state        <= ST_ARMED;
                        alarm_sticky <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (sw_ack && fifo_empty && (raw == 3'b000) && !event_hit) begin
                        state        <= ST_IDLE;
                        alarm_sticky <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    alarm_sticky <= 1'b0;
                end
            endcase
        end
    end

    total_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (record),
        .rdata (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_sentinel_event_reporter.sv
// Bench for sentinel_event_reporter: directed scenarios plus random traffic,
// all checked against a cycle-indexed queue model of the event stream.
module tb_sentinel_event_reporter;

    localparam int TS_W   = 32;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int RW     = TS_W + 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            entropy_alarm;
    logic            thermal_shutdown;
    logic            system_halt;
    logic            evt_valid;
    logic            evt_ready;
    logic [RW-1:0]   evt_data;
    logic            sw_ack;
    logic            alarm_sticky;
    logic [DROP_W-1:0] drop_count;
    logic [2:0]      fifo_level;

    int checks = 0;
    int errors = 0;

    // Model: records waiting for software, cycle number, and the inputs seen
    // in the two previous cycles.
    logic [RW-1:0] mq[$];
    logic [31:0]   m_ts;
    logic [2:0]    m_older;
    logic [2:0]    m_newer;
    int            m_drops;
    bit            m_ovf;
    bit            m_sticky;

    always #5 clk = ~clk;

    sentinel_event_reporter #(
        .TS_W   (TS_W),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .entropy_alarm    (entropy_alarm),
        .thermal_shutdown (thermal_shutdown),
        .system_halt      (system_halt),
        .evt_valid        (evt_valid),
        .evt_ready        (evt_ready),
        .evt_data         (evt_data),
        .sw_ack           (sw_ack),
        .alarm_sticky     (alarm_sticky),
        .drop_count       (drop_count),
        .fifo_level       (fifo_level)
    );

    // One clock cycle: drive inputs for the cycle, advance the model, then
    // land just after the edge where outputs are stable.
    task automatic tick(input bit rst, input logic [2:0] in, input bit rdy, input bit ack);
        logic [2:0] rose;
        bit         was_empty;
        @(negedge clk);
        rst_n = !rst;
        {system_halt, thermal_shutdown, entropy_alarm} = in;
        evt_ready = rdy;
        sw_ack    = ack;
        if (rst) begin
            mq.delete();
            m_ts = 0; m_older = 0; m_newer = 0;
            m_drops = 0; m_ovf = 0; m_sticky = 0;
        end else begin
            rose      = m_newer & ~m_older;
            was_empty = (mq.size() == 0);
            if (!was_empty && rdy) void'(mq.pop_front());
            if (rose != 3'b000) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({m_ovf, rose, m_ts});
                    m_ovf = 0;
                end else begin
                    if (m_drops < 255) m_drops++;
                    m_ovf = 1;
                end
                m_sticky = 1;
            end else if (ack && was_empty && (in == 3'b000)) begin
                m_sticky = 0;
            end
            m_ts    = m_ts + 1;
            m_older = m_newer;
            m_newer = in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 3'b111, 0, 0);
            checks++;
            if (evt_valid !== 1'b0 || drop_count !== 8'd0 || alarm_sticky !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold got v=%b d=%0d s=%b exp v=0 d=0 s=0", evt_valid, drop_count, alarm_sticky);
            end
        end
        checks++;
        if (fifo_level !== 3'd0 || evt_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_level got lvl=%0d data=%h exp lvl=0 data=0", fifo_level, evt_data);
        end
        tick(0, 3'b111, 0, 0);
        tick(0, 3'b111, 0, 0);
        checks++;
        if (evt_valid !== 1'b1 || evt_data[35:32] !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL reset_release_cause got v=%b cause=%b exp v=1 cause=0111", evt_valid, evt_data[35:32]);
        end
        checks++;
        if (mq.size() != 1 || evt_data !== mq[0]) begin
            errors++;
            $display("[TB] FAIL reset_release_rec got %h exp %h size=%0d", evt_data, (mq.size() > 0) ? mq[0] : '0, mq.size());
        end
        tick(0, 3'b000, 1, 0);
        tick(0, 3'b000, 1, 0);
    endtask

    task automatic test_single();
        tick(1, 3'b000, 0, 0);
        tick(1, 3'b000, 0, 0);
        for (int i = 0; i < 200 && m_ts != 100; i++) tick(0, 3'b000, 1, 0);
        tick(0, 3'b001, 1, 0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early got v=%b exp 0", evt_valid);
        end
        tick(0, 3'b001, 1, 0);
        checks++;
        if (evt_valid !== 1'b1 || evt_data !== 36'h1_0000_0065 || alarm_sticky !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_rec got v=%b data=%h s=%b exp v=1 data=100000065 s=1", evt_valid, evt_data, alarm_sticky);
        end
        tick(0, 3'b000, 1, 0);
        checks++;
        if (evt_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL single_pulse got v=%b lvl=%0d exp v=0 lvl=0", evt_valid, fifo_level);
        end
    endtask

    task automatic test_simultaneous();
        tick(0, 3'b000, 0, 0);
        tick(0, 3'b110, 0, 0);
        tick(0, 3'b110, 0, 0);
        tick(0, 3'b110, 0, 0);
        checks++;
        if (fifo_level !== 3'd1 || evt_data[34:32] !== 3'b110) begin
            errors++;
            $display("[TB] FAIL simul_cause got lvl=%0d cause=%b exp lvl=1 cause=110", fifo_level, evt_data[34:32]);
        end
        checks++;
        if (evt_data !== mq[0]) begin
            errors++;
            $display("[TB] FAIL simul_rec got %h exp %h", evt_data, mq[0]);
        end
        tick(0, 3'b000, 1, 0);
    endtask

    task automatic test_overflow();
        tick(1, 3'b000, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 3'b001, 0, 0);
            tick(0, 3'b000, 0, 0);
        end
        tick(0, 3'b000, 0, 0);
        checks++;
        if (fifo_level !== 3'd4 || drop_count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL ovf_counts got lvl=%0d drops=%0d exp lvl=4 drops=2", fifo_level, drop_count);
        end
        for (int k = 0; k < 2; k++) begin
            tick(0, 3'b000, 1, 0);
            tick(0, 3'b001, 0, 0);
            tick(0, 3'b000, 0, 0);
            tick(0, 3'b000, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_data !== mq[0]) begin
                errors++;
                $display("[TB] FAIL ovf_drain%0d got %h exp %h", i, evt_data, mq[0]);
            end
            if (i >= 2) begin
                checks++;
                if (evt_data[35] !== ((i == 2) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL ovf_flag%0d got %b exp %b", i, evt_data[35], (i == 2));
                end
            end
            tick(0, 3'b000, 1, 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            tick(0, 3'b010, 0, 0);
            tick(0, 3'b000, 0, 0);
        end
        tick(0, 3'b001, 0, 0);
        tick(0, 3'b001, 1, 0);
        checks++;
        if (fifo_level !== 3'd4 || drop_count !== 8'd2) begin
            errors++;
            $display("[TB] FAIL full_pop got lvl=%0d drops=%0d exp lvl=4 drops=2", fifo_level, drop_count);
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 3'b000, 0, 0);
            checks++;
            if (evt_valid !== 1'b1 || evt_data !== mq[0]) begin
                errors++;
                $display("[TB] FAIL hold%0d got v=%b data=%h exp v=1 data=%h", i, evt_valid, evt_data, mq[0]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (evt_data !== mq[0]) begin
                errors++;
                $display("[TB] FAIL tail_drain%0d got %h exp %h", i, evt_data, mq[0]);
            end
            if (i == 3) begin
                checks++;
                if (evt_data[35:32] !== 4'b0001) begin
                    errors++;
                    $display("[TB] FAIL tail_cause got %b exp 0001", evt_data[35:32]);
                end
            end
            tick(0, 3'b000, 1, 0);
        end
    endtask

    task automatic test_ack_race();
        tick(0, 3'b000, 1, 1);
        checks++;
        if (alarm_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_clear got %b exp 0", alarm_sticky);
        end
        tick(0, 3'b100, 0, 0);
        tick(0, 3'b100, 0, 1);
        checks++;
        if (alarm_sticky !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ack_race got %b exp 1", alarm_sticky);
        end
        tick(0, 3'b000, 0, 1);
        checks++;
        if (alarm_sticky !== 1'b1 || alarm_sticky !== m_sticky) begin
            errors++;
            $display("[TB] FAIL ack_nonempty got %b exp 1", alarm_sticky);
        end
        tick(0, 3'b000, 1, 0);
        tick(0, 3'b000, 0, 1);
        checks++;
        if (alarm_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_after_drain got %b exp 0", alarm_sticky);
        end
    endtask

    task automatic test_wrap();
        tick(0, 3'b000, 0, 0);
        force dut.ts = 32'hFFFF_FFFF;
        #1;
        release dut.ts;
        m_ts = 32'hFFFF_FFFF;
        tick(0, 3'b001, 0, 0);
        tick(0, 3'b000, 0, 0);
        checks++;
        if (evt_valid !== 1'b1 || evt_data[31:0] !== 32'd0) begin
            errors++;
            $display("[TB] FAIL wrap_ts got v=%b ts=%h exp v=1 ts=0", evt_valid, evt_data[31:0]);
        end
        checks++;
        if (evt_data !== mq[0]) begin
            errors++;
            $display("[TB] FAIL wrap_rec got %h exp %h", evt_data, mq[0]);
        end
        tick(0, 3'b000, 1, 0);
    endtask

    task automatic test_random();
        logic [2:0] in;
        for (int i = 0; i < 600; i++) begin
            in = 3'($urandom) & 3'($urandom);
            tick(($urandom_range(0, 149) == 0), in, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            checks++;
            if (evt_valid !== (mq.size() != 0) || fifo_level !== 3'(mq.size())
                || evt_data !== ((mq.size() != 0) ? mq[0] : '0)) begin
                errors++;
                $display("[TB] FAIL rand_stream%0d got v=%b lvl=%0d data=%h exp lvl=%0d data=%h",
                         i, evt_valid, fifo_level, evt_data, mq.size(), (mq.size() != 0) ? mq[0] : '0);
            end
            checks++;
            if (drop_count !== 8'(m_drops) || alarm_sticky !== m_sticky) begin
                errors++;
                $display("[TB] FAIL rand_status%0d got d=%0d s=%b exp d=%0d s=%b",
                         i, drop_count, alarm_sticky, m_drops, m_sticky);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {system_halt, thermal_shutdown, entropy_alarm} = 3'b111;
        evt_ready = 1'b0;
        sw_ack    = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_overflow();
        test_back_to_back();
        test_ack_race();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
